// File: rtl/axi_ddr3_rdarb.sv
// axi_ddr3_rdarb: round-robin merge of two AXI4 read masters onto one controller read port
module axi_ddr3_rdarb #(
    parameter int ADDRS       = 29,
    parameter int WIDTH       = 32,
    parameter int ID_WIDTH    = 4,
    parameter int ORDER_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                s0_arvalid_i,
    output logic                s0_arready_o,
    input  logic [ADDRS-1:0]    s0_araddr_i,
    input  logic [ID_WIDTH-1:0] s0_arid_i,
    input  logic [7:0]          s0_arlen_i,
    input  logic [1:0]          s0_arburst_i,
    output logic                s0_rvalid_o,
    input  logic                s0_rready_i,
    output logic                s0_rlast_o,
    output logic [1:0]          s0_rresp_o,
    output logic [ID_WIDTH-1:0] s0_rid_o,
    output logic [WIDTH-1:0]    s0_rdata_o,
    input  logic                s1_arvalid_i,
    output logic                s1_arready_o,
    input  logic [ADDRS-1:0]    s1_araddr_i,
    input  logic [ID_WIDTH-1:0] s1_arid_i,
    input  logic [7:0]          s1_arlen_i,
    input  logic [1:0]          s1_arburst_i,
    output logic                s1_rvalid_o,
    input  logic                s1_rready_i,
    output logic                s1_rlast_o,
    output logic [1:0]          s1_rresp_o,
    output logic [ID_WIDTH-1:0] s1_rid_o,
    output logic [WIDTH-1:0]    s1_rdata_o,
    output logic                m_arvalid_o,
    input  logic                m_arready_i,
    output logic [ADDRS-1:0]    m_araddr_o,
    output logic [ID_WIDTH-1:0] m_arid_o,
    output logic [7:0]          m_arlen_o,
    output logic [1:0]          m_arburst_o,
    input  logic                m_rvalid_i,
    output logic                m_rready_o,
    input  logic                m_rlast_i,
    input  logic [1:0]          m_rresp_i,
    input  logic [ID_WIDTH-1:0] m_rid_i,
    input  logic [WIDTH-1:0]    m_rdata_i
);
    localparam int PW = $clog2(ORDER_DEPTH);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t                 r_state;
    logic                   r_rr;
    logic [ORDER_DEPTH-1:0] r_fifo;
    logic [PW:0]            r_wptr, r_rptr;
    logic [ADDRS-1:0]       r_araddr;
    logic [ID_WIDTH-1:0]    r_arid;
    logic [7:0]             r_arlen;
    logic [1:0]             r_arburst;
    logic w_empty, w_full, w_acc, w_win0, w_win1, w_push, w_pop, w_head, w_sel0, w_sel1;
    assign w_empty = r_wptr == r_rptr;
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    // FIFO slot is reserved at accept time, so a burst still sitting in OREG is already counted
    assign w_acc   = reset_n && !w_full && (r_state == IDLE || m_arready_i);
    assign w_win0  = s0_arvalid_i && (!s1_arvalid_i || !r_rr);
    assign w_win1  = s1_arvalid_i && (!s0_arvalid_i || r_rr);
    assign w_push  = w_acc && (s0_arvalid_i || s1_arvalid_i);
    assign s0_arready_o = w_acc && w_win0;
    assign s1_arready_o = w_acc && w_win1;
    assign m_arvalid_o  = r_state == HOLD;
    assign m_araddr_o   = r_araddr;
    assign m_arid_o     = r_arid;
    assign m_arlen_o    = r_arlen;
    assign m_arburst_o  = r_arburst;
    assign w_head = r_fifo[r_rptr[PW-1:0]];
    assign w_sel0 = !w_empty && !w_head;
    assign w_sel1 = !w_empty && w_head;
    assign m_rready_o  = w_sel0 ? s0_rready_i : (w_sel1 && s1_rready_i);
    assign w_pop       = m_rvalid_i && m_rready_o && m_rlast_i;
    assign s0_rvalid_o = m_rvalid_i && w_sel0;
    assign s0_rlast_o  = w_sel0 && m_rlast_i;
    assign s0_rresp_o  = w_sel0 ? m_rresp_i : '0;
    assign s0_rid_o    = w_sel0 ? m_rid_i : '0;
    assign s0_rdata_o  = w_sel0 ? m_rdata_i : '0;
    assign s1_rvalid_o = m_rvalid_i && w_sel1;
    assign s1_rlast_o  = w_sel1 && m_rlast_i;
    assign s1_rresp_o  = w_sel1 ? m_rresp_i : '0;
    assign s1_rid_o    = w_sel1 ? m_rid_i : '0;
    assign s1_rdata_o  = w_sel1 ? m_rdata_i : '0;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rr    <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_state                  <= HOLD;
                r_rr                     <= !r_rr;
                r_fifo[r_wptr[PW-1:0]]   <= w_win1;
                r_wptr                   <= r_wptr + 1'b1;
                r_araddr                 <= w_win1 ? s1_araddr_i : s0_araddr_i;
                r_arid                   <= w_win1 ? s1_arid_i : s0_arid_i;
                r_arlen                  <= w_win1 ? s1_arlen_i : s0_arlen_i;
                r_arburst                <= w_win1 ? s1_arburst_i : s0_arburst_i;
            end else if (m_arready_i) begin
                r_state <= IDLE;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end
    a_rvalid_when_empty: assert property (@(posedge clock) disable iff (!reset_n) !(m_rvalid_i && w_empty));
endmodule

// File: tb/tb_axi_ddr3_rdarb.sv
// tb_axi_ddr3_rdarb: vector table, directed corner sequences and a queue-based random model
module tb_axi_ddr3_rdarb;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic s0_arvalid_i, s0_arready_o, s0_rvalid_o, s0_rready_i, s0_rlast_o;
    logic [28:0] s0_araddr_i;
    logic [3:0] s0_arid_i, s0_rid_o;
    logic [7:0] s0_arlen_i;
    logic [1:0] s0_arburst_i, s0_rresp_o;
    logic [31:0] s0_rdata_o;
    logic s1_arvalid_i, s1_arready_o, s1_rvalid_o, s1_rready_i, s1_rlast_o;
    logic [28:0] s1_araddr_i;
    logic [3:0] s1_arid_i, s1_rid_o;
    logic [7:0] s1_arlen_i;
    logic [1:0] s1_arburst_i, s1_rresp_o;
    logic [31:0] s1_rdata_o;
    logic m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o, m_rlast_i;
    logic [28:0] m_araddr_o;
    logic [3:0] m_arid_o, m_rid_i;
    logic [7:0] m_arlen_o;
    logic [1:0] m_arburst_o, m_rresp_i;
    logic [31:0] m_rdata_i;
    int checks = 0;
    int errors = 0;
    always #5 clock = ~clock;
    axi_ddr3_rdarb dut (
        .clock(clock), .reset_n(reset_n),
        .s0_arvalid_i(s0_arvalid_i), .s0_arready_o(s0_arready_o), .s0_araddr_i(s0_araddr_i),
        .s0_arid_i(s0_arid_i), .s0_arlen_i(s0_arlen_i), .s0_arburst_i(s0_arburst_i),
        .s0_rvalid_o(s0_rvalid_o), .s0_rready_i(s0_rready_i), .s0_rlast_o(s0_rlast_o),
        .s0_rresp_o(s0_rresp_o), .s0_rid_o(s0_rid_o), .s0_rdata_o(s0_rdata_o),
        .s1_arvalid_i(s1_arvalid_i), .s1_arready_o(s1_arready_o), .s1_araddr_i(s1_araddr_i),
        .s1_arid_i(s1_arid_i), .s1_arlen_i(s1_arlen_i), .s1_arburst_i(s1_arburst_i),
        .s1_rvalid_o(s1_rvalid_o), .s1_rready_i(s1_rready_i), .s1_rlast_o(s1_rlast_o),
        .s1_rresp_o(s1_rresp_o), .s1_rid_o(s1_rid_o), .s1_rdata_o(s1_rdata_o),
        .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
        .m_arid_o(m_arid_o), .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
        .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rlast_i(m_rlast_i),
        .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i)
    );
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic clear_inputs;
        s0_arvalid_i = 0; s0_araddr_i = '0; s0_arid_i = '0; s0_arlen_i = '0; s0_arburst_i = '0; s0_rready_i = 0;
        s1_arvalid_i = 0; s1_araddr_i = '0; s1_arid_i = '0; s1_arlen_i = '0; s1_arburst_i = '0; s1_rready_i = 0;
        m_arready_i = 0; m_rvalid_i = 0; m_rlast_i = 0; m_rresp_i = '0; m_rid_i = '0; m_rdata_i = '0;
    endtask
    task automatic reset_dut;
        clear_inputs();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask
    typedef struct {
        logic s0v, s1v, rdy, e0, e1, ev;
        logic [3:0] eid;
    } vec_t;
    vec_t tbl[8];
    typedef struct {
        logic [28:0] addr;
        logic [3:0] id;
        logic [7:0] len;
        logic [1:0] burst;
    } ar_t;
    int gq[$];
    int cq[$];
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        tbl[0] = '{1, 1, 1, 1, 0, 0, 4'h0};
        tbl[1] = '{1, 1, 1, 0, 1, 1, 4'h3};
        tbl[2] = '{1, 1, 0, 0, 0, 1, 4'hA};
        tbl[3] = '{0, 1, 1, 0, 1, 1, 4'hA};
        tbl[4] = '{1, 1, 1, 0, 1, 1, 4'hA};
        tbl[5] = '{1, 1, 1, 0, 0, 1, 4'hA};
        tbl[6] = '{1, 1, 0, 0, 0, 0, 4'h0};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 4'h0};
        // reset state, with both masters requesting while reset is held
        clear_inputs();
        s0_arvalid_i = 1; s1_arvalid_i = 1; s0_rready_i = 1; s1_rready_i = 1;
        tick();
        tick();
        chk("reset_outs", {s0_arready_o, s1_arready_o, m_arvalid_o, m_rready_o, s0_rvalid_o, s1_rvalid_o}, 6'b0);
        // arbitration vector table
        reset_dut();
        s0_araddr_i = 29'h1000; s0_arid_i = 4'h3; s0_arburst_i = 2'd1;
        s1_araddr_i = 29'h2000; s1_arid_i = 4'hA; s1_arburst_i = 2'd1;
        for (int i = 0; i < 8; i++) begin
            s0_arvalid_i = tbl[i].s0v; s1_arvalid_i = tbl[i].s1v; m_arready_i = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_s0rdy", i), s0_arready_o, tbl[i].e0);
            chk($sformatf("tbl%0d_s1rdy", i), s1_arready_o, tbl[i].e1);
            chk($sformatf("tbl%0d_mvalid", i), m_arvalid_o, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("tbl%0d_mid", i), m_arid_o, tbl[i].eid);
            tick();
        end
        // full FIFO: pop of first burst reopens exactly one slot
        s0_arvalid_i = 1; s0_rready_i = 1; m_rvalid_i = 1; m_rlast_i = 1; m_rid_i = 4'h3;
        #1;
        chk("full_pop_rdy", s0_arready_o, 1'b0);
        chk("full_pop_mrready", m_rready_o, 1'b1);
        tick();
        m_rvalid_i = 0;
        #1;
        chk("reopen_rdy", s0_arready_o, 1'b1);
        tick();
        #1;
        chk("refull_rdy", s0_arready_o, 1'b0);
        // single S0 burst of four beats
        reset_dut();
        s0_arvalid_i = 1; s0_araddr_i = 29'h100; s0_arid_i = 4'h5; s0_arlen_i = 8'd3; s0_arburst_i = 2'd1;
        #1;
        chk("t1_accept", s0_arready_o, 1'b1);
        tick();
        s0_arvalid_i = 0;
        #1;
        chk("t1_mar", {m_arvalid_o, m_araddr_o, m_arlen_o}, {1'b1, 29'h100, 8'd3});
        m_arready_i = 1;
        tick();
        m_arready_i = 0;
        #1;
        chk("t1_drained", m_arvalid_o, 1'b0);
        s0_rready_i = 1; s1_rready_i = 1;
        for (int b = 0; b < 4; b++) begin
            m_rvalid_i = 1; m_rdata_i = 32'hD000 + b; m_rid_i = 4'h5; m_rresp_i = 2'd0; m_rlast_i = (b == 3);
            #1;
            chk($sformatf("t1_b%0d_s0", b), {s0_rvalid_o, s0_rlast_o, s0_rid_o, s0_rdata_o}, {1'b1, b == 3, 4'h5, 32'hD000 + b});
            chk($sformatf("t1_b%0d_s1", b), {s1_rvalid_o, s1_rlast_o, s1_rdata_o}, 34'b0);
            chk($sformatf("t1_b%0d_mrdy", b), m_rready_o, 1'b1);
            tick();
        end
        m_rvalid_i = 0; m_rlast_i = 0;
        #1;
        chk("t1_empty", m_rready_o, 1'b0);
        // S1 burst stalled by its rready; S0 burst queued behind it
        reset_dut();
        s1_arvalid_i = 1; s1_arid_i = 4'hA; s1_arlen_i = 8'd1; m_arready_i = 1;
        #1;
        chk("t4_s1acc", s1_arready_o, 1'b1);
        tick();
        s1_arvalid_i = 0; s0_arvalid_i = 1; s0_arid_i = 4'h3; s0_arlen_i = 8'd0;
        #1;
        chk("t4_s0acc", s0_arready_o, 1'b1);
        tick();
        s0_arvalid_i = 0;
        tick();
        m_arready_i = 0; s0_rready_i = 1; s1_rready_i = 0;
        m_rvalid_i = 1; m_rid_i = 4'hA; m_rdata_i = 32'h11; m_rlast_i = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_stall%0d", k), {m_rready_o, s0_rvalid_o, s1_rvalid_o}, 3'b001);
            tick();
        end
        s1_rready_i = 1;
        #1;
        chk("t4_s1b0", {m_rready_o, s1_rvalid_o, s1_rdata_o}, {2'b11, 32'h11});
        tick();
        m_rdata_i = 32'h12; m_rlast_i = 1;
        #1;
        chk("t4_s1b1", {s0_rvalid_o, s1_rvalid_o, s1_rlast_o, s1_rdata_o}, {3'b011, 32'h12});
        tick();
        m_rid_i = 4'h3; m_rdata_i = 32'h20;
        #1;
        chk("t4_s0b0", {s0_rvalid_o, s1_rvalid_o, s0_rid_o, s0_rdata_o}, {2'b10, 4'h3, 32'h20});
        tick();
        m_rvalid_i = 0; m_rlast_i = 0;
        #1;
        chk("t4_empty", m_rready_o, 1'b0);
        // reset in the middle of a four-beat burst
        reset_dut();
        s0_arvalid_i = 1; s0_arlen_i = 8'd3; m_arready_i = 1;
        tick();
        s0_arvalid_i = 0;
        tick();
        s0_rready_i = 1; m_rvalid_i = 1; m_rdata_i = 32'h77;
        #1;
        chk("t6_beat1", s0_rvalid_o, 1'b1);
        tick();
        reset_n = 0; m_rvalid_i = 0; s0_arvalid_i = 1; s1_arvalid_i = 1; s1_rready_i = 1;
        tick();
        #1;
        chk("t6_inreset", {s0_arready_o, s1_arready_o, m_arvalid_o, m_rready_o, s0_rvalid_o, s1_rvalid_o}, 6'b0);
        reset_n = 1;
        #1;
        chk("t6_after", {s0_arready_o, s1_arready_o, m_arvalid_o, m_rready_o}, 4'b1000);
        tick();
        // random traffic against a queue model
        begin
            logic rr, ov, rv, acc, w0, w1, ne, h, mrdy, lst;
            ar_t oreg, a0, a1;
            int cb;
            logic [31:0] rd;
            logic [3:0] rid;
            logic [1:0] rsp;
            logic [39:0] e0, e1;
            reset_dut();
            gq.delete(); cq.delete();
            rr = 0; ov = 0; rv = 0; cb = 0; rd = '0; rid = '0; rsp = '0; oreg = '{default: '0};
            for (int c = 0; c < 2000; c++) begin
                a0 = '{29'($urandom), 4'($urandom), 8'($urandom_range(0, 3)), 2'($urandom)};
                a1 = '{29'($urandom), 4'($urandom), 8'($urandom_range(0, 3)), 2'($urandom)};
                s0_arvalid_i = ($urandom % 3) != 0; s1_arvalid_i = ($urandom % 3) != 0;
                s0_araddr_i = a0.addr; s0_arid_i = a0.id; s0_arlen_i = a0.len; s0_arburst_i = a0.burst;
                s1_araddr_i = a1.addr; s1_arid_i = a1.id; s1_arlen_i = a1.len; s1_arburst_i = a1.burst;
                s0_rready_i = ($urandom % 4) != 0; s1_rready_i = ($urandom % 4) != 0;
                m_arready_i = ($urandom % 3) != 0;
                if (!rv && cq.size() > 0 && ($urandom % 2) == 1) begin
                    rv = 1; rd = $urandom; rid = 4'($urandom); rsp = 2'($urandom);
                end
                lst = rv && (cb == cq[0]);
                m_rvalid_i = rv; m_rdata_i = rd; m_rid_i = rid; m_rresp_i = rsp; m_rlast_i = lst;
                #1;
                acc = (gq.size() < 4) && (!ov || m_arready_i);
                w0 = s0_arvalid_i && (!s1_arvalid_i || !rr);
                w1 = s1_arvalid_i && (!s0_arvalid_i || rr);
                chk("rnd_arready", {s0_arready_o, s1_arready_o}, {acc && w0, acc && w1});
                chk("rnd_mar", {m_arvalid_o, m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o},
                    ov ? {1'b1, oreg.addr, oreg.id, oreg.len, oreg.burst} : {1'b0, m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o});
                ne = gq.size() > 0;
                h = ne ? gq[0][0] : 1'b0;
                mrdy = ne && (h ? s1_rready_i : s0_rready_i);
                e0 = (ne && !h) ? {rv, lst, rsp, rid, rd} : 40'b0;
                e1 = (ne && h) ? {rv, lst, rsp, rid, rd} : 40'b0;
                chk("rnd_mrready", m_rready_o, mrdy);
                chk("rnd_r0", {s0_rvalid_o, s0_rlast_o, s0_rresp_o, s0_rid_o, s0_rdata_o}, e0);
                chk("rnd_r1", {s1_rvalid_o, s1_rlast_o, s1_rresp_o, s1_rid_o, s1_rdata_o}, e1);
                if (rv && mrdy) begin
                    rv = 0;
                    cb++;
                    if (lst) begin
                        void'(cq.pop_front());
                        void'(gq.pop_front());
                        cb = 0;
                    end
                end
                if (ov && m_arready_i) cq.push_back(int'(oreg.len));
                if (acc && (w0 || w1)) begin
                    gq.push_back(w1 ? 1 : 0);
                    oreg = w1 ? a1 : a0;
                    ov = 1;
                    rr = !rr;
                end else if (m_arready_i) begin
                    ov = 0;
                end
                tick();
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
